// File: rtl/seq_squarer_pkg.sv
// Shared types and width helpers for the sequential shift-add squarer.
package seq_squarer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter only has to reach w-1; guard w<2 so $clog2 never yields 0.
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    function automatic int res_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/seq_squarer_dp.sv
// Shift-add datapath: one partial product per clock, multiplicand A, multiplier M, product P.
module seq_squarer_dp
    import seq_squarer_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       step,
    input  logic [WIDTH-1:0]           opnd,
    output logic [res_w(WIDTH)-1:0]    prod,
    output logic                       last_step
);

    localparam int RW    = res_w(WIDTH);
    localparam int CNT_W = cnt_w(WIDTH);

    logic [RW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [RW-1:0]    p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        a_d   = a_q;
        m_d   = m_q;
        p_d   = p_q;
        cnt_d = cnt_q;
        if (load) begin
            a_d   = {{WIDTH{1'b0}}, opnd};
            m_d   = opnd;
            p_d   = '0;
            cnt_d = '0;
        end else if (step) begin
            if (m_q[0]) p_d = p_q + a_q;
            a_d   = a_q << 1;
            m_d   = m_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            m_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            m_q   <= m_d;
            p_q   <= p_d;
            cnt_q <= cnt_d;
        end
    end

    assign prod      = p_q;
    assign last_step = step && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_squarer.sv
// Multi-cycle unsigned squarer with valid/ready handshake on both sides.
// Define SEQ_SQUARER_SIGNED_EN to treat in_data as two's complement and square its magnitude.
module seq_squarer
    import seq_squarer_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out_data
);

    if (WIDTH < 2) begin : g_width_chk
        $error("seq_squarer: WIDTH must be >= 2");
    end

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] operand;

`ifdef SEQ_SQUARER_SIGNED_EN
    // -2^(W-1) negates to itself, which read unsigned is exactly its magnitude.
    assign operand = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;
`else
    assign operand = in_data;
`endif

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (last_step) state_d = DONE;
            DONE: if (out_ready) state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    seq_squarer_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (state_q == BUSY),
        .opnd      (operand),
        .prod      (out_data),
        .last_step (last_step)
    );

    assign out_valid = out_valid_q;

endmodule
